// File: rtl/inta_sequencer.sv
// CPU-side interrupt acknowledge sequencer: synchronises INT, issues the INTA
// pulse train, captures the vector bytes and hands them to the core over valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for synchronised INT with irq_enable
// S_LOW   | INTA low for PULSE_W clocks; DATABUS captured on last clock
// S_GAP   | INTA high for GAP_W clocks between pulses
// S_VALID | vector presented to the core, waiting for vec_ready
// S_HOLD  | GAP_W clocks of holdoff so the controller can drop INT
module inta_sequencer #(
    parameter bit MODE_8086   = 1'b1,
    parameter int PULSE_W     = 2,
    parameter int GAP_W       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INT,
    output logic        INTA,
    input  logic [7:0]  DATABUS,
    input  logic        irq_enable,
    output logic        vec_valid,
    input  logic        vec_ready,
    output logic [15:0] vec_data,
    output logic        call_err,
    output logic        busy
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] P_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GAP_W - 1);
    localparam logic [1:0]    NPULSE = MODE_8086 ? 2'd2 : 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_GAP,
        S_VALID,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          k_q, k_d;
    logic                sample;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                int_s;
    logic [7:0]          byte1_q, byte2_q, byte3_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INT};
        end
    end

    assign int_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        sample  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (int_s && irq_enable) begin
                    state_d = S_LOW;
                    cnt_d   = P_LOAD;
                    k_d     = 2'd1;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    sample = 1'b1;
                    if (k_q == NPULSE) begin
                        state_d = S_VALID;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = G_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = P_LOAD;
                    k_d     = k_q + 2'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_VALID: begin
                if (vec_ready) begin
                    state_d = S_HOLD;
                    cnt_d   = G_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // INTA and vec_valid are registered copies of the next state, so they
    // change on the same edge as the state they belong to.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            k_q       <= 2'd0;
            INTA      <= 1'b1;
            vec_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            INTA      <= (state_d != S_LOW);
            vec_valid <= (state_d == S_VALID);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte1_q  <= 8'h00;
            byte2_q  <= 8'h00;
            byte3_q  <= 8'h00;
            call_err <= 1'b0;
        end else if (sample) begin
            case (k_q)
                2'd1:    byte1_q <= DATABUS;
                2'd2:    byte2_q <= DATABUS;
                default: byte3_q <= DATABUS;
            endcase
            if (k_q == NPULSE) begin
                call_err <= !MODE_8086 && (byte1_q != 8'hCD);
            end
        end
    end

    assign vec_data = MODE_8086 ? {8'h00, byte2_q} : {byte3_q, byte2_q};
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: one 8086-mode and one 8080-mode instance sharing a
// modelled interrupt controller; delivered vectors are checked against a scoreboard.
module tb_inta_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        int_86, int_80;
    logic [7:0]  DATABUS;
    logic        irq_enable, vec_ready;
    logic        inta_86, vec_valid_86, call_err_86, busy_86;
    logic        inta_80, vec_valid_80, call_err_80, busy_80;
    logic [15:0] vec_data_86, vec_data_80;
    logic        inta_all;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit          sel;
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [7:0] bus_bytes [3];
    int         pulse_idx = 0;

    always #5 CLK = ~CLK;

    inta_sequencer #(.MODE_8086(1'b1), .PULSE_W(2), .GAP_W(2), .SYNC_STAGES(2)) u_86 (
        .CLK(CLK), .RST_N(RST_N), .INT(int_86), .INTA(inta_86), .DATABUS(DATABUS),
        .irq_enable(irq_enable), .vec_valid(vec_valid_86), .vec_ready(vec_ready),
        .vec_data(vec_data_86), .call_err(call_err_86), .busy(busy_86)
    );

    inta_sequencer #(.MODE_8086(1'b0), .PULSE_W(2), .GAP_W(2), .SYNC_STAGES(2)) u_80 (
        .CLK(CLK), .RST_N(RST_N), .INT(int_80), .INTA(inta_80), .DATABUS(DATABUS),
        .irq_enable(irq_enable), .vec_valid(vec_valid_80), .vec_ready(vec_ready),
        .vec_data(vec_data_80), .call_err(call_err_80), .busy(busy_80)
    );

    assign inta_all = inta_86 & inta_80;

    // Controller model: each INTA falling edge puts the next byte on the bus.
    always @(negedge inta_all) begin
        pulse_idx = pulse_idx + 1;
        if (pulse_idx >= 1 && pulse_idx <= 3) DATABUS = bus_bytes[pulse_idx-1];
    end

    // Scoreboard: a transfer happens on the next rising edge when valid & ready.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N === 1'b1 && vec_ready === 1'b1 && vec_valid_86 === 1'b1) begin
            tests_run++;
            if (sb.size() == 0 || sb[0].sel != 1'b0) begin
                tests_failed++;
                $display("FAIL sb_86_unexpected: got transfer data=%h, required no transfer", vec_data_86);
            end else begin
                e = sb.pop_front();
                if (vec_data_86 !== e.data || call_err_86 !== e.err) begin
                    tests_failed++;
                    $display("FAIL sb_86: got data=%h err=%b, required data=%h err=%b",
                             vec_data_86, call_err_86, e.data, e.err);
                end
            end
        end
        if (RST_N === 1'b1 && vec_ready === 1'b1 && vec_valid_80 === 1'b1) begin
            tests_run++;
            if (sb.size() == 0 || sb[0].sel != 1'b1) begin
                tests_failed++;
                $display("FAIL sb_80_unexpected: got transfer data=%h, required no transfer", vec_data_80);
            end else begin
                e = sb.pop_front();
                if (vec_data_80 !== e.data || call_err_80 !== e.err) begin
                    tests_failed++;
                    $display("FAIL sb_80: got data=%h err=%b, required data=%h err=%b",
                             vec_data_80, call_err_80, e.data, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_bytes(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        bus_bytes[0] = b1;
        bus_bytes[1] = b2;
        bus_bytes[2] = b3;
        pulse_idx    = 0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 200 && (busy_86 || busy_80 || sb.size() != 0); i++) tick();
        tests_run++;
        if (busy_86 || busy_80 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL wait_done: got busy86=%b busy80=%b pending=%0d, required idle with 0 pending",
                     busy_86, busy_80, sb.size());
        end
        repeat (3) tick();
    endtask

    task automatic run_seq(input bit sel, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [15:0] data, input logic err);
        int i;
        load_bytes(b1, b2, b3);
        sb.push_back('{sel: sel, data: data, err: err});
        if (sel) int_80 = 1'b1; else int_86 = 1'b1;
        for (i = 0; i < 20 && !(sel ? busy_80 : busy_86); i++) tick();
        tests_run++;
        if (!(sel ? busy_80 : busy_86)) begin
            tests_failed++;
            $display("FAIL run_seq_start: got busy=0, required busy=1 within 20 clk");
        end
        int_86 = 1'b0;
        int_80 = 1'b0;
        wait_done();
    endtask

    task automatic test_reset();
        load_bytes(8'h11, 8'h48, 8'h00);
        sb.push_back('{sel: 1'b0, data: 16'h0048, err: 1'b0});
        RST_N  = 1'b0;
        int_86 = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (inta_86 !== 1'b1 || vec_valid_86 !== 1'b0 || busy_86 !== 1'b0 ||
            vec_data_86 !== 16'h0000 || call_err_80 !== 1'b0 || vec_data_80 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_values: got inta=%b valid=%b busy=%b data=%h err80=%b, required 1 0 0 0000 0",
                     inta_86, vec_valid_86, busy_86, vec_data_86, call_err_80);
        end
        RST_N = 1'b1;
        tick();
        tick();
        tests_run++;
        if (inta_86 !== 1'b1 || busy_86 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sync: edge1 got inta=%b busy=%b, required 1 0", inta_86, busy_86);
        end
        tick();
        tests_run++;
        if (inta_86 !== 1'b0 || busy_86 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_start: edge2 got inta=%b busy=%b, required 0 1", inta_86, busy_86);
        end
        int_86 = 1'b0;
        wait_done();
    endtask

    task automatic test_8086_timing();
        logic [12:0] inta_pat, valid_pat, busy_pat;
        inta_pat  = 13'b1111100110011;
        valid_pat = 13'b0000100000000;
        busy_pat  = 13'b0011111111100;
        load_bytes(8'h77, 8'h48, 8'h00);
        sb.push_back('{sel: 1'b0, data: 16'h0048, err: 1'b0});
        int_86 = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            tick();
            tests_run++;
            if (inta_86 !== inta_pat[e] || vec_valid_86 !== valid_pat[e] || busy_86 !== busy_pat[e]) begin
                tests_failed++;
                $display("FAIL timing_8086 edge%0d: got inta=%b valid=%b busy=%b, required %b %b %b",
                         e, inta_86, vec_valid_86, busy_86, inta_pat[e], valid_pat[e], busy_pat[e]);
            end
            if (e == 3) int_86 = 1'b0;
        end
        wait_done();
    endtask

    task automatic test_8080();
        run_seq(1'b1, 8'hCD, 8'h20, 8'h10, 16'h1020, 1'b0);
        run_seq(1'b1, 8'h00, 8'h20, 8'h10, 16'h1020, 1'b1);
        run_seq(1'b1, 8'hCD, 8'hEF, 8'hBE, 16'hBEEF, 1'b0);
        run_seq(1'b0, 8'h00, 8'hA5, 8'h00, 16'h00A5, 1'b0);
    endtask

    task automatic test_irq_enable();
        irq_enable = 1'b0;
        int_86     = 1'b1;
        repeat (20) begin
            tick();
            tests_run++;
            if (inta_86 !== 1'b1 || busy_86 !== 1'b0) begin
                tests_failed++;
                $display("FAIL irq_disabled: got inta=%b busy=%b, required 1 0", inta_86, busy_86);
            end
        end
        load_bytes(8'h00, 8'h3C, 8'h00);
        sb.push_back('{sel: 1'b0, data: 16'h003C, err: 1'b0});
        irq_enable = 1'b1;
        tick();
        tests_run++;
        if (inta_86 !== 1'b0 || busy_86 !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_enable_start: got inta=%b busy=%b, required 0 1", inta_86, busy_86);
        end
        irq_enable = 1'b0;
        int_86     = 1'b0;
        wait_done();
        irq_enable = 1'b1;
    endtask

    task automatic test_backpressure();
        int i;
        load_bytes(8'h00, 8'h5A, 8'h00);
        sb.push_back('{sel: 1'b0, data: 16'h005A, err: 1'b0});
        vec_ready = 1'b0;
        int_86    = 1'b1;
        for (i = 0; i < 30 && !vec_valid_86; i++) tick();
        tests_run++;
        if (vec_valid_86 !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_reach_valid: got valid=%b, required 1 within 30 clk", vec_valid_86);
        end
        repeat (10) begin
            tick();
            tests_run++;
            if (vec_valid_86 !== 1'b1 || vec_data_86 !== 16'h005A || inta_86 !== 1'b1 || busy_86 !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold: got valid=%b data=%h inta=%b busy=%b, required 1 005a 1 1",
                         vec_valid_86, vec_data_86, inta_86, busy_86);
            end
        end
        vec_ready = 1'b1;
        int_86    = 1'b0;
        tick();
        tests_run++;
        if (vec_valid_86 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_single: got valid=%b after transfer, required 0", vec_valid_86);
        end
        wait_done();
    endtask

    task automatic test_reset_mid();
        int i;
        load_bytes(8'h00, 8'h99, 8'h00);
        int_86 = 1'b1;
        for (i = 0; i < 30 && pulse_idx < 2; i++) tick();
        tests_run++;
        if (pulse_idx < 2 || inta_86 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_second_low: got pulses=%0d inta=%b, required 2 0", pulse_idx, inta_86);
        end
        #2;
        RST_N  = 1'b0;
        int_86 = 1'b0;
        #1;
        tests_run++;
        if (inta_86 !== 1'b1 || busy_86 !== 1'b0 || vec_valid_86 !== 1'b0 || vec_data_86 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got inta=%b busy=%b valid=%b data=%h, required 1 0 0 0000",
                     inta_86, busy_86, vec_valid_86, vec_data_86);
        end
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (20) begin
            tick();
            tests_run++;
            if (inta_86 !== 1'b1 || busy_86 !== 1'b0 || vec_valid_86 !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_reset_idle: got inta=%b busy=%b valid=%b, required 1 0 0",
                         inta_86, busy_86, vec_valid_86);
            end
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        int_86     = 1'b0;
        int_80     = 1'b0;
        DATABUS    = 8'h00;
        irq_enable = 1'b1;
        vec_ready  = 1'b1;
        test_reset();
        test_8086_timing();
        test_8080();
        test_irq_enable();
        test_backpressure();
        test_reset_mid();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: got %0d pending vectors, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
